pilha_param: RTL and testbench

PILHA_PARAM -- requirements
Module: pilha_param

---
 rtl/pilha_pkg.sv | 13 +
 rtl/pilha_param.sv | 162 ++++++++++++++++
 tb/tb_pilha_param.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/pilha_pkg.sv
// pilha_pkg -- shared definitions for the pilha_param stack.
//   PILHA_CTRL_WIDTH : width of the ctrl operation code
//   PILHA_FLUSH/PUSH/POP/SWAP : ctrl encodings
package pilha_pkg;

    localparam int PILHA_CTRL_WIDTH = 2;

    localparam logic [PILHA_CTRL_WIDTH-1:0] PILHA_FLUSH = 2'b00;
    localparam logic [PILHA_CTRL_WIDTH-1:0] PILHA_PUSH  = 2'b01;
    localparam logic [PILHA_CTRL_WIDTH-1:0] PILHA_POP   = 2'b10;
    localparam logic [PILHA_CTRL_WIDTH-1:0] PILHA_SWAP  = 2'b11;

endpackage

// File: rtl/pilha_param.sv
// pilha_param -- parameterised LIFO stack held in a circular buffer.
//
// Ports
//   clk      in   single clock, rising edge
//   rst      in   synchronous active-high reset
//   active   in   operation strobe; ctrl is ignored while low
//   ctrl     in   FLUSH / PUSH / POP / SWAP (see pilha_pkg)
//   data_in  in   word written by PUSH and SWAP
//   data_out out  top of stack, 0 when empty (combinational from registered state)
//   count    out  number of valid entries, 0..2**DEPTH_LOG2
//   full     out  count == 2**DEPTH_LOG2
//   empty    out  count == 0
//   error    out  outcome of the most recent active operation
//   err_ovf  out  sticky overflow flag, cleared by FLUSH or rst
//   err_unf  out  sticky underflow flag, cleared by FLUSH or rst
//
// Build option
//   PILHA_WRAP_EN : when defined, PUSH on a full stack overwrites the oldest
//                   entry and advances the base instead of being rejected.
module pilha_param
    import pilha_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH_LOG2 = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        active,
    input  logic [PILHA_CTRL_WIDTH-1:0] ctrl,
    input  logic [DATA_WIDTH-1:0]       data_in,
    output logic [DATA_WIDTH-1:0]       data_out,
    output logic [DEPTH_LOG2:0]         count,
    output logic                        full,
    output logic                        empty,
    output logic                        error,
    output logic                        err_ovf,
    output logic                        err_unf
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2-1:0] IDX_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_ONE  = 1;
    localparam logic [DEPTH_LOG2:0]   CNT_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] base_q,  base_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  error_q, error_d;
    logic                  ovf_q,   ovf_d;
    logic                  unf_q,   unf_d;

    logic                  wr_en;
    logic [DEPTH_LOG2-1:0] wr_idx;
    logic [DEPTH_LOG2-1:0] top_idx;
    logic [DEPTH_LOG2-1:0] push_idx;
    logic                  is_full;
    logic                  is_empty;

    assign is_full  = (count_q == CNT_FULL);
    assign is_empty = (count_q == '0);

    // With count == DEPTH the low count bits are zero, so push_idx lands on
    // base (the oldest entry) and top_idx on base-1, both as required.
    assign top_idx  = base_q + count_q[DEPTH_LOG2-1:0] - IDX_ONE;
    assign push_idx = base_q + count_q[DEPTH_LOG2-1:0];

    always_comb begin
        count_d = count_q;
        base_d  = base_q;
        error_d = error_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        wr_en   = 1'b0;
        wr_idx  = push_idx;

        if (active) begin
            case (ctrl)
                PILHA_FLUSH: begin
                    count_d = '0;
                    error_d = 1'b0;
                    ovf_d   = 1'b0;
                    unf_d   = 1'b0;
                end
                PILHA_PUSH: begin
                    if (!is_full) begin
                        wr_en   = 1'b1;
                        count_d = count_q + CNT_ONE;
                        error_d = 1'b0;
                    end else begin
`ifdef PILHA_WRAP_EN
                        wr_en   = 1'b1;
                        base_d  = base_q + IDX_ONE;
                        error_d = 1'b0;
                        ovf_d   = 1'b1;
`else
                        error_d = 1'b1;
                        ovf_d   = 1'b1;
`endif
                    end
                end
                PILHA_POP: begin
                    if (!is_empty) begin
                        count_d = count_q - CNT_ONE;
                        error_d = 1'b0;
                    end else begin
                        error_d = 1'b1;
                        unf_d   = 1'b1;
                    end
                end
                default: begin
                    // SWAP: replace top, or act as PUSH on an empty stack
                    wr_en   = 1'b1;
                    error_d = 1'b0;
                    if (!is_empty) begin
                        wr_idx = top_idx;
                    end else begin
                        count_d = CNT_ONE;
                    end
                end
            endcase
        end

        // Reset wins over a coincident operation, including its storage write.
        if (rst) begin
            wr_en = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            base_q  <= '0;
            error_q <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            base_q  <= base_d;
            error_q <= error_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_idx] <= data_in;
        end
    end

    assign data_out = is_empty ? '0 : mem_q[top_idx];
    assign count    = count_q;
    assign full     = is_full;
    assign empty    = is_empty;
    assign error    = error_q;
    assign err_ovf  = ovf_q;
    assign err_unf  = unf_q;

endmodule

// File: tb/tb_pilha_param.sv
// tb_pilha_param -- directed scoreboard bench for pilha_param
// (DATA_WIDTH=16, DEPTH_LOG2=2). Honours PILHA_WRAP_EN like the design.
module tb_pilha_param;
    import pilha_pkg::*;

    localparam int DW = 16;
    localparam int DL = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          active = 1'b0;
    logic [1:0]    ctrl = PILHA_FLUSH;
    logic [DW-1:0] data_in = '0;
    logic [DW-1:0] data_out;
    logic [DL:0]   count;
    logic          full, empty, error, err_ovf, err_unf;

    pilha_param #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .clk      (clk),
        .rst      (rst),
        .active   (active),
        .ctrl     (ctrl),
        .data_in  (data_in),
        .data_out (data_out),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .error    (error),
        .err_ovf  (err_ovf),
        .err_unf  (err_unf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [DW-1:0] dout;
        logic [DL:0]   cnt;
        logic          err;
        logic          ovf;
        logic          unf;
    } exp_t;

    exp_t  exp_q  [$];
    string name_q [$];

    int n_vec  = 0;
    int n_fail = 0;

    // Monitor: one expectation per applied edge, checked at the next falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string nm;
            logic  e_full, e_empty;
            e  = exp_q.pop_front();
            nm = name_q.pop_front();
            e_full  = (e.cnt == 3'd4);
            e_empty = (e.cnt == 3'd0);
            n_vec++;
            if (data_out !== e.dout || count !== e.cnt || error !== e.err ||
                err_ovf !== e.ovf || err_unf !== e.unf ||
                full !== e_full || empty !== e_empty) begin
                n_fail++;
                $display("FAIL %s: got dout=%h cnt=%0d err=%b ovf=%b unf=%b full=%b empty=%b, want dout=%h cnt=%0d err=%b ovf=%b unf=%b full=%b empty=%b",
                         nm, data_out, count, error, err_ovf, err_unf, full, empty,
                         e.dout, e.cnt, e.err, e.ovf, e.unf, e_full, e_empty);
            end
        end
    end

    task automatic op(input logic r, input logic a, input logic [1:0] c,
                      input logic [DW-1:0] d, input string nm,
                      input logic [DW-1:0] e_do, input int e_cnt,
                      input logic e_err, input logic e_ovf, input logic e_unf);
        exp_t e;
        @(negedge clk);
        #1;
        rst     = r;
        active  = a;
        ctrl    = c;
        data_in = d;
        e.dout = e_do;
        e.cnt  = e_cnt[DL:0];
        e.err  = e_err;
        e.ovf  = e_ovf;
        e.unf  = e_unf;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    initial begin
        // reset state
        op(1, 0, PILHA_FLUSH, 16'h0, "reset",      16'h0000, 0, 0, 0, 0);

        // basic push / pop
        op(0, 1, PILHA_PUSH, 16'hA1, "push_a1",    16'h00A1, 1, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'hB2, "push_b2",    16'h00B2, 2, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'hC3, "push_c3",    16'h00C3, 3, 0, 0, 0);
        op(0, 1, PILHA_POP,  16'h0,  "pop_c3",     16'h00B2, 2, 0, 0, 0);

        // underflow, sticky unf, idle holds error
        op(1, 0, PILHA_FLUSH, 16'h0, "rst2",       16'h0000, 0, 0, 0, 0);
        op(0, 1, PILHA_POP,  16'h0,  "pop_empty",  16'h0000, 0, 1, 0, 1);
        op(0, 0, PILHA_FLUSH, 16'h0, "idle_flush", 16'h0000, 0, 1, 0, 1);
        op(0, 0, PILHA_PUSH, 16'h33, "idle_push",  16'h0000, 0, 1, 0, 1);
        op(0, 1, PILHA_PUSH, 16'h11, "push_11",    16'h0011, 1, 0, 0, 1);

        // fill, then push on full
        op(1, 0, PILHA_FLUSH, 16'h0, "rst3",       16'h0000, 0, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h1,  "fill_1",     16'h0001, 1, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h2,  "fill_2",     16'h0002, 2, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h3,  "fill_3",     16'h0003, 3, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h4,  "fill_4",     16'h0004, 4, 0, 0, 0);
`ifdef PILHA_WRAP_EN
        op(0, 1, PILHA_PUSH, 16'h5,  "push_full",  16'h0005, 4, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_5",    16'h0004, 3, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_4",    16'h0003, 2, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_3",    16'h0002, 1, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_2",    16'h0000, 0, 0, 1, 0);
`else
        op(0, 1, PILHA_PUSH, 16'h5,  "push_full",  16'h0004, 4, 1, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_4",    16'h0003, 3, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_3",    16'h0002, 2, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_2",    16'h0001, 1, 0, 1, 0);
        op(0, 1, PILHA_POP,  16'h0,  "drain_1",    16'h0000, 0, 0, 1, 0);
`endif
        op(0, 1, PILHA_POP,  16'h0,  "unf_after",  16'h0000, 0, 1, 1, 1);
        op(0, 1, PILHA_FLUSH, 16'h0, "flush_all",  16'h0000, 0, 0, 0, 0);

        // swap (base may be non-zero here in the wrap build)
        op(0, 1, PILHA_PUSH, 16'h10, "push_10",    16'h0010, 1, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h20, "push_20",    16'h0020, 2, 0, 0, 0);
        op(0, 1, PILHA_SWAP, 16'h99, "swap_99",    16'h0099, 2, 0, 0, 0);
        op(0, 1, PILHA_POP,  16'h0,  "pop_99",     16'h0010, 1, 0, 0, 0);
        op(0, 1, PILHA_POP,  16'h0,  "pop_10",     16'h0000, 0, 0, 0, 0);
        op(0, 1, PILHA_SWAP, 16'h7,  "swap_empty", 16'h0007, 1, 0, 0, 0);

        // inactive cycles hold state; reset overrides a push
        op(0, 1, PILHA_PUSH, 16'h21, "push_21",    16'h0021, 2, 0, 0, 0);
        op(0, 1, PILHA_PUSH, 16'h32, "push_32",    16'h0032, 3, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            op(0, 0, PILHA_POP, 16'h0, "idle_pop", 16'h0032, 3, 0, 0, 0);
        op(1, 1, PILHA_PUSH, 16'h55, "rst_push",   16'h0000, 0, 0, 0, 0);
        op(0, 1, PILHA_SWAP, 16'h66, "post_rst",   16'h0066, 1, 0, 0, 0);

        // let the monitor drain, bounded
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        @(negedge clk);
        if (exp_q.size() > 0) begin
            n_fail++;
            $display("FAIL drain: got %0d unchecked expectations, want 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
